// File: rtl/sipo_deser.sv
// sipo_deser: MSB-first serial-in/parallel-out deserializer with a
// valid/ready output holding register and sticky overrun detection.
// Optional even-parity bit per word when SIPO_DESER_PARITY_EN is defined.
module sipo_deser #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  output logic             par_err
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_sreg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_pout;
  logic             r_pout_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_complete;
  logic [WIDTH-1:0] w_word;

`ifdef SIPO_DESER_PARITY_EN
  typedef enum logic {SHIFT = 1'b0, PAR = 1'b1} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_par_err;
  logic   w_par_err;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SHIFT;
    else      r_state <= w_state_nxt;
  end

  // Next-state, shift/count update and word completion with parity bit
  always_comb begin
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    w_word      = r_sreg;
    w_par_err   = 1'b0;
    if (sin_en) begin
      if (r_state == PAR) begin
        w_complete  = 1'b1;
        w_par_err   = ^{r_sreg, sin};
        w_state_nxt = SHIFT;
      end else begin
        w_sreg_nxt = {r_sreg[WIDTH-2:0], sin};
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = PAR;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Parity flag travels with the word through the holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_err <= 1'b0;
    end else if (w_complete && (!r_pout_valid || pout_ready)) begin
      r_par_err <= w_par_err;
    end
  end

  assign par_err = r_par_err;
`else
  // Shift/count update; the word completes on the WIDTH-th strobe
  always_comb begin
    w_sreg_nxt = r_sreg;
    w_cnt_nxt  = r_cnt;
    w_complete = 1'b0;
    w_word     = r_sreg;
    if (sin_en) begin
      w_sreg_nxt = {r_sreg[WIDTH-2:0], sin};
      if (r_cnt == CNT_W'(WIDTH - 1)) begin
        w_cnt_nxt  = '0;
        w_complete = 1'b1;
        w_word     = w_sreg_nxt;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  assign par_err = 1'b0;
`endif

  // Shift register and bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Output holding register: accept, consume, or drop with sticky overrun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_complete) begin
      if (!r_pout_valid || pout_ready) begin
        r_pout       <= w_word;
        r_pout_valid <= 1'b1;
      end else begin
        r_overrun    <= 1'b1;
      end
    end else if (r_pout_valid && pout_ready) begin
      r_pout_valid <= 1'b0;
    end
  end

  assign pout       = r_pout;
  assign pout_valid = r_pout_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: directed cases plus randomized traffic.
module tb_sipo_deser;

  localparam int W = 8;
`ifdef SIPO_DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  typedef struct packed {
    logic [W-1:0] w;
    logic         pe;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_en = 1'b0;
  logic         pout_ready = 1'b0;
  logic [W-1:0] pout;
  logic         pout_valid;
  logic         overrun;
  logic         par_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  // Reference model state
  exp_t         exp_q[$];
  logic [63:0]  m_acc = '0;
  int           m_nb = 0;
  logic         m_valid = 1'b0;
  logic         m_ovr = 1'b0;

  sipo_deser #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .pout       (pout),
    .pout_valid (pout_valid),
    .pout_ready (pout_ready),
    .overrun    (overrun),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_acc   = '0;
    m_nb    = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  // One clock edge of the behavioural model, using the inputs present at the edge
  task automatic model_step();
    exp_t e;
    bit   done;
    done = 0;
    if (!rst) return;
    if (sin_en) begin
      m_acc = (m_acc << 1) | 64'(sin);
      m_nb++;
      if (m_nb == NB) begin
        done = 1;
        e.w  = W'(m_acc >> (NB - W));
`ifdef SIPO_DESER_PARITY_EN
        e.pe = 1'($countones(m_acc) % 2);
`else
        e.pe = 1'b0;
`endif
        m_acc = '0;
        m_nb  = 0;
      end
    end
    if (done) begin
      if (!m_valid || pout_ready) begin
        exp_q.push_back(e);
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && pout_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick(input logic en, input logic b, input logic rdy);
    @(posedge clk);
    model_step();
    #1;
    sin_en     = en;
    sin        = b;
    pout_ready = rdy;
  endtask

  function automatic logic rdy_of(input int mode);
    if (mode == 2) return logic'($urandom_range(3, 0) != 0);
    return logic'(mode == 1);
  endfunction

  // Send n bits MSB-first with random idle gaps; mode 0=low,1=high,2=random
  task automatic send_bits(input logic [63:0] bits, input int n, input int maxgap,
                           input int md, input int ml);
    int gap;
    for (int i = n - 1; i >= 0; i--) begin
      gap = $urandom_range(maxgap, 0);
      repeat (gap) tick(1'b0, 1'b0, rdy_of(md));
      tick(1'b1, bits[i], (i == 0) ? rdy_of(ml) : rdy_of(md));
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic p, input int maxgap,
                           input int md, input int ml);
`ifdef SIPO_DESER_PARITY_EN
    send_bits(64'({w, p}), NB, maxgap, md, ml);
`else
    send_bits(64'(w), NB, maxgap, md, ml);
    if (p) begin end
`endif
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  // Monitor: compares handshakes against the scoreboard and flags every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started && rst) begin
        check("pout_valid", 64'(pout_valid), 64'(m_valid));
        check("overrun", 64'(overrun), 64'(m_ovr));
        if (pout_valid && pout_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("pout", 64'(pout), 64'(e.w));
            check("par_err", 64'(par_err), 64'(e.pe));
          end
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_pout", 64'(pout), 64'(0));
    check("rst_valid", 64'(pout_valid), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_par_err", 64'(par_err), 64'(0));
    model_reset();
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    started = 1;

    // Basic word, ready high throughout
    send_word(8'hA5, 1'b0, 0, 1, 1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("basic_pout", 64'(pout), 64'hA5);
    check("basic_valid_hi", 64'(pout_valid), 64'(1));
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("basic_valid_lo", 64'(pout_valid), 64'(0));
    check("basic_overrun", 64'(overrun), 64'(0));

    // Gapped strobes
    send_word(8'hA5, 1'b0, 5, 1, 1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("gap_pout", 64'(pout), 64'hA5);
    tick(1'b0, 1'b0, 1'b1);

    // Back-pressure and overrun
    do_reset();
    send_word(8'h3C, 1'b0, 0, 0, 0);
    send_word(8'hC3, 1'b0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_pout", 64'(pout), 64'h3C);
    check("bp_overrun", 64'(overrun), 64'(1));
    check("bp_valid", 64'(pout_valid), 64'(1));
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_valid_drop", 64'(pout_valid), 64'(0));
    check("bp_overrun_sticky", 64'(overrun), 64'(1));

    // Same-edge consume and complete
    do_reset();
    send_word(8'h81, 1'b0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("se_first", 64'(pout), 64'h81);
    send_word(8'h7E, 1'b0, 0, 0, 1);
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("se_pout", 64'(pout), 64'h7E);
    check("se_valid", 64'(pout_valid), 64'(1));
    check("se_overrun", 64'(overrun), 64'(0));
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Reset mid-word
    send_bits(64'hF, 4, 0, 1, 1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_pout", 64'(pout), 64'(0));
    check("mid_rst_valid", 64'(pout_valid), 64'(0));
    check("mid_rst_overrun", 64'(overrun), 64'(0));
    check("mid_rst_par_err", 64'(par_err), 64'(0));
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    send_word(8'h12, 1'b0, 0, 1, 1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("post_rst_pout", 64'(pout), 64'h12);
    check("post_rst_valid", 64'(pout_valid), 64'(1));
    tick(1'b0, 1'b0, 1'b1);

`ifdef SIPO_DESER_PARITY_EN
    // Parity good and bad
    do_reset();
    send_word(8'hA5, 1'b0, 0, 1, 1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("par_good", 64'(par_err), 64'(0));
    send_word(8'hA5, 1'b1, 0, 1, 1);
    tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("par_bad", 64'(par_err), 64'(1));
    tick(1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic with random back-pressure
    do_reset();
    for (int k = 0; k < 40; k++) begin
      send_word(W'($urandom), 1'($urandom), 3, 2, 2);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer: the receiving end of the team's 1-bit serial links, which transmit MSB-first by shifting left. It gathers WIDTH qualified serial bits into a word and presents the word on a valid/ready parallel port. It detects words lost to back-pressure. It sits between a serial line and word-oriented downstream logic.

## Interface
- WIDTH, 8, data bits per word; legal range 2 to 32
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-low reset
- sin  input  1  serial data bit
- sin_en  input  1  bit strobe; sin is sampled only on edges where sin_en=1
- pout  output  WIDTH  assembled word; first received bit is at pout[WIDTH-1]
- pout_valid  output  1  pout holds an unconsumed word
- pout_ready  input  1  downstream accepts pout
- overrun  output  1  sticky flag: a completed word was dropped
- par_err  output  1  parity error for the word on pout (see Configuration)

## Operation
- Internal state:
  - shift register sreg[WIDTH-1:0]
  - bit counter cnt, ceil(log2(WIDTH+1)) bits
  - FSM with states SHIFT and PAR
- Reset (rst=0, asynchronous) clears sreg, cnt, pout, pout_valid, overrun and par_err to 0, and sets the FSM to SHIFT.
- SHIFT state, on each edge with sin_en=1:
  - sreg <= {sreg[WIDTH-2:0], sin}
  - cnt increments
  - On the WIDTH-th bit, the word is complete: the next value of sreg is the word, and cnt returns to 0.
- Word completion without parity: the word is offered to the output holding register on the same edge, and the FSM stays in SHIFT.
- Output holding register load rule, applied on the completion edge:
  - If pout_valid=0, or pout_valid=1 and pout_ready=1 on that edge: pout <= word and pout_valid <= 1.
  - Otherwise the word is discarded, pout and pout_valid are unchanged, and overrun <= 1.
- Consume: on an edge with pout_valid=1, pout_ready=1 and no completion, pout_valid <= 0. pout keeps its last value.
- overrun clears only on reset.
- Edges with sin_en=0 leave sreg, cnt and the FSM unchanged.
- pout_ready is ignored when pout_valid=0.

## Timing
- pout and pout_valid update on the same edge that samples the final bit, so they are visible one clock after that edge.
- Minimum word spacing is WIDTH strobes (WIDTH+1 with parity).
- Back-to-back words are supported without loss when pout_ready=1 at every completion edge.
- A completion on the same edge as a consume reloads pout; pout_valid stays 1 with no gap.
- Reset asserted mid-word discards the partial word. The first strobe after reset release is bit WIDTH-1 of a new word.
- Reset release is synchronous to clk at the integrating level. The block treats the first edge with rst=1 as a normal edge.

## Configuration
- Macro: SIPO_DESER_PARITY_EN.
- When defined:
  - After the WIDTH-th data bit the FSM enters PAR, and the next strobe is an even-parity bit.
  - The word completes on that parity strobe, and the FSM returns to SHIFT.
  - par_err <= ^{word, parity_bit} is loaded together with pout and follows the same accept/drop rule.
  - par_err is valid while pout_valid=1.
- When not defined:
  - The PAR state and the parity logic are absent.
  - par_err is a constant 0.
  - Words complete on the WIDTH-th strobe.

## Test plan
- Basic word:
  - Stimulus: WIDTH=8, strobe bits 1,0,1,0,0,1,0,1 on consecutive cycles, pout_ready=1.
  - Required response: pout=8'hA5, pout_valid high for exactly one cycle, overrun=0.
- Gapped strobes:
  - Stimulus: the same bits with sin_en=0 cycles between them (random gaps of 0 to 5 cycles).
  - Required response: pout=8'hA5, with no change to sreg or cnt during the gaps.
- Back-pressure and overrun:
  - Stimulus: pout_ready=0; send 8'h3C, then 8'hC3.
  - Required response: pout stays 8'h3C, overrun=1 after the second word completes.
  - Then set pout_ready=1: pout_valid drops after one cycle and overrun stays 1.
- Same-edge consume and complete:
  - Stimulus: assert pout_ready only on the completion edge of the second word (8'h81 then 8'h7E).
  - Required response: pout=8'h7E, pout_valid continuously 1, overrun=0.
- Reset mid-word:
  - Stimulus: drive rst=0 asynchronously after 4 bits of 8'hFF, then send 8'h12.
  - Required response: all outputs are 0 while reset is asserted; the next word is 8'h12.
- Parity (SIPO_DESER_PARITY_EN only):
  - Stimulus: send 8'hA5 followed by parity bit 0.
  - Required response: par_err=0.
  - Then send 8'hA5 followed by parity bit 1: par_err=1.
